serial_adder: RTL and testbench

//  Bit-serial N-bit adder built around one registered full-adder cell: accepts two

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder (FSM state encoding, width ceiling).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial adder's RUN path.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b via inverted b and forced carry-in).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  full_adder_cell u_fa (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .ci(c),
    .s (s_bit),
    .co(c_next)
  );

  assign sum_next  = {s_bit, sum_sh[WIDTH-1:1]};
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b_load;
            c      <= c_load;
            cnt    <= '0;
            sum_sh <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          c      <= c_next;
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Last bit: publish the assembled word; cnt cleared so it never runs past LAST.
          if (cnt == LAST) begin
            sum   <= sum_next;
            cout  <= c_next;
            cnt   <= '0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed + random bench for serial_adder (WIDTH=8); sub cases only when SERIAL_ADDER_SUB_EN is set.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int WIDTH = 8;
  localparam int BOUND = WIDTH_MAX + 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int compared = 0;
  int mismatched = 0;
  logic [WIDTH:0] sb_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y,
                                           logic ci, logic sb);
    logic [WIDTH-1:0] ny;
    ny = ~y;
    if (sb) return {1'b0, x} + {1'b0, ny} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) check("sub_unsupported", 32'd1, 32'd0);
`endif
  endtask

  // Presents one operand bundle and returns after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic sb, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < BOUND) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = x; b = y; cin = ci; set_sub(sb);
    in_valid = 1'b1;
    if (push) sb_q.push_back(model(x, y, ci, sb));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      step();
      lat++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [WIDTH:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(tag, 32'({cout, sum}), 32'(e));
    end
  endtask

  task automatic finish_op(input string tag, input bit chk_lat);
    int lat;
    wait_out(lat);
    if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    pop_check(tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ops_a[3];
    logic [WIDTH-1:0] ops_b[3];
    int acc[3];
    int idx;
    int lat;
    bit accepting;
    bit delivering;
    logic sb;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum_cout", 32'({cout, sum}), 32'd0);

    // 1: zero operands, latency
    start_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    finish_op("zero", 1'b1);
    check("idle_after_out", 32'(in_ready), 32'd1);

    // 2: carry propagation
    start_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    finish_op("ff_plus_01", 1'b1);
    start_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
    finish_op("a5_plus_5a_c", 1'b1);
    check("sum_held_idle", 32'({cout, sum}), 32'h100);

    // 3: backpressure; in_valid pulses during DONE must be ignored
    start_op(8'h3C, 8'h4B, 1'b1, 1'b0, 1'b1);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 8'h77; b = 8'h88; cin = 1'b1;
      step();
      check("bp_sum_stable", 32'({cout, sum}), 32'(sb_q[0]));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    pop_check("bp_result");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    step();
    check("bp_no_capture", 32'(busy), 32'd0);

    // 4: reset in the third RUN cycle aborts the operation
    start_op(8'hEE, 8'h11, 1'b1, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'({cout, sum}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    start_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    finish_op("after_abort", 1'b1);

    // 5: back-to-back with both handshakes held high
    ops_a = '{8'h01, 8'h80, 8'hC3};
    ops_b = '{8'h02, 8'h80, 8'h3D};
    idx = 0;
    a = ops_a[0]; b = ops_b[0]; cin = 1'b0; set_sub(1'b0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && (idx < 3 || sb_q.size() > 0); cyc++) begin
      accepting = in_valid && in_ready;
      delivering = out_valid && out_ready;
      if (accepting) sb_q.push_back(model(a, b, cin, 1'b0));
      if (delivering) pop_check("b2b_result");
      step();
      if (accepting) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          a = ops_a[idx]; b = ops_b[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("b2b_accepts", 32'(idx), 32'd3);
    if (idx == 3) begin
      check("b2b_gap_1", 32'(acc[1] - acc[0]), 32'(WIDTH + 2));
      check("b2b_gap_2", 32'(acc[2] - acc[1]), 32'(WIDTH + 2));
    end
    check("b2b_drained", 32'(sb_q.size()), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtraction
    start_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
    finish_op("sub_10_01", 1'b1);
    start_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b1);
    finish_op("sub_01_02", 1'b1);
`endif

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`else
      sb = 1'b0;
`endif
      start_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sb, 1'b1);
      finish_op("random", (i % 16 == 0));
    end
    set_sub(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
